// File: rtl/next_mc_sequencer.sv
// ============================================================================
// next_mc_sequencer : multicycle RV32I control FSM with req/ack memory,
//                     bus-timeout / illegal-opcode trap and retire counter
// Revision 1.0
// ============================================================================
`default_nettype none

module next_mc_sequencer #(
  parameter int MAX_WAIT = 200,
  parameter int WAIT_W   = 8,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                alu_zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_src,
  output logic                instr_flop_wen,
  output logic                pc_wen,
  output logic                reg_write,
  output logic [1:0]          alu_a_src,
  output logic [1:0]          alu_b_src,
  output logic [1:0]          result_src,
  output logic [2:0]          imm_sel,
  output logic [3:0]          alu_control,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state
);

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_MEMADR = 5'd2,  S_MEMRD  = 5'd3,
    S_MEMWB  = 5'd4,  S_MEMWR  = 5'd5,  S_EXEC_R = 5'd6,  S_EXEC_I = 5'd7,
    S_ALUWB  = 5'd8,  S_BRANCH = 5'd9,  S_JAL    = 5'd10, S_JALR   = 5'd11,
    S_JALR2  = 5'd12, S_LINK   = 5'd13, S_LUI    = 5'd14, S_AUIPC  = 5'd15,
    S_TRAP   = 5'd16
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RD1 = 2'b10, A_ALUOUT = 2'b11;
  localparam logic [1:0] B_RD2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10, B_NOT1 = 2'b11;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_LOAD = 2'b01, RES_ALU = 2'b10, RES_IMM = 2'b11;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

  localparam bit             TIMEOUT_EN = (MAX_WAIT != 0);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic [1:0]            cause_q, cause_d;
  logic [3:0]            arith_op, br_op;
  logic                  br_taken;
  logic                  unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = (state_q == S_EXEC_R && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  // EQ/NE compare via SUB; signed/unsigned LT via SLT/SLTU. Taken polarity flips
  // for NE and the LT pair, which share funct3[0]^funct3[2] = 1.
  always_comb begin
    br_op = ALU_SUB;
    if (funct3[2]) br_op = funct3[1] ? ALU_SLTU : ALU_SLT;
    br_taken = alu_zero ^ (funct3[0] ^ funct3[2]);
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = '0;
    cause_d        = cause_q;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    addr_src       = 1'b0;
    instr_flop_wen = 1'b0;
    pc_wen         = 1'b0;
    reg_write      = 1'b0;
    alu_a_src      = A_PC;
    alu_b_src      = B_RD2;
    result_src     = RES_ALUOUT;
    imm_sel        = IMM_I;
    alu_control    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          instr_flop_wen = 1'b1;
          pc_wen         = 1'b1;
          alu_b_src      = B_FOUR;
          result_src     = RES_ALU;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_a_src = A_OLDPC;
        alu_b_src = B_IMM;
        imm_sel   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BR:             state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            state_d = S_TRAP;
            cause_d = 2'd1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_a_src   = A_RD1;
        alu_b_src   = (state_q == S_EXEC_R) ? B_RD2 : B_IMM;
        alu_control = arith_op;
        state_d     = S_ALUWB;
      end
      S_AUIPC: begin
        alu_a_src = A_OLDPC;
        alu_b_src = B_IMM;
        imm_sel   = IMM_U;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_LUI: begin
        imm_sel    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_a_src   = A_RD1;
        alu_control = br_op;
        pc_wen      = br_taken;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_a_src  = A_OLDPC;
        alu_b_src  = B_IMM;
        imm_sel    = IMM_J;
        result_src = RES_ALU;
        pc_wen     = 1'b1;
        state_d    = S_LINK;
      end
      S_JALR: begin
        alu_a_src = A_RD1;
        alu_b_src = B_IMM;
        state_d   = S_JALR2;
      end
      S_JALR2: begin
        alu_a_src   = A_ALUOUT;
        alu_b_src   = B_NOT1;
        alu_control = ALU_AND;
        result_src  = RES_ALU;
        pc_wen      = 1'b1;
        state_d     = S_LINK;
      end
      S_LINK: begin
        alu_a_src  = A_OLDPC;
        alu_b_src  = B_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMADR: begin
        alu_a_src = A_RD1;
        alu_b_src = B_IMM;
        imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (mem_ack) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_LOAD;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        if (mem_ack) state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Every request-holding state shares the same wait/timeout bookkeeping.
    if (mem_req && !mem_ack) begin
      wait_d = wait_q + 1'b1;
      if (TIMEOUT_EN && wait_q == LAST_WAIT) begin
        state_d = S_TRAP;
        cause_d = 2'd2;
      end
    end

    // Reset silences the bus at once rather than waiting for the flop edge.
    if (rst) begin
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      addr_src       = 1'b0;
      instr_flop_wen = 1'b0;
      pc_wen         = 1'b0;
      reg_write      = 1'b0;
      alu_a_src      = A_PC;
      alu_b_src      = B_RD2;
      result_src     = RES_ALUOUT;
      imm_sel        = IMM_I;
      alu_control    = ALU_ADD;
    end

    retired_d = retired_q;
    if (state_d == S_FETCH && state_q != S_FETCH) retired_d = retired_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
    end
  end

  // TRAP has no 4-bit slot of its own; the debug port shows it as 4'hF with trap=1.
  assign state      = (state_q == S_TRAP) ? 4'hF : state_q[3:0];
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_next_mc_sequencer.sv
// ============================================================================
// tb_next_mc_sequencer : scoreboard bench for the multicycle control sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_next_mc_sequencer;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2, ST_MEMRD = 4'd3;
  localparam logic [3:0] ST_MEMWB = 4'd4,  ST_MEMWR  = 4'd5,  ST_EXEC_R = 4'd6, ST_EXEC_I = 4'd7;
  localparam logic [3:0] ST_ALUWB = 4'd8,  ST_BRANCH = 4'd9,  ST_JAL    = 4'd10, ST_JALR  = 4'd11;
  localparam logic [3:0] ST_JALR2 = 4'd12, ST_LINK   = 4'd13, ST_LUI    = 4'd14, ST_AUIPC = 4'd15;
  localparam logic [3:0] ST_TRAP  = 4'hF;

  logic        clk, rst, alu_zero, mem_ack;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        mem_req, mem_we, addr_src, instr_flop_wen, pc_wen, reg_write, trap;
  logic [1:0]  alu_a_src, alu_b_src, result_src, trap_cause;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_control, state;
  logic [31:0] retired;

  next_mc_sequencer #(.MAX_WAIT(4), .WAIT_W(8), .RETIRE_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .addr_src(addr_src), .instr_flop_wen(instr_flop_wen), .pc_wen(pc_wen),
    .reg_write(reg_write), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
    .result_src(result_src), .imm_sel(imm_sel), .alu_control(alu_control),
    .trap(trap), .trap_cause(trap_cause), .retired(retired), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       req, we, as, ifw, pcw, rw;
    logic [1:0] a, b, res;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       trap;
    logic [1:0] cause;
  } ctl_t;

  ctl_t        sb[$];
  ctl_t        mon_exp, mon_got;
  int          vectors = 0;
  int          miscompares = 0;
  int          req_cycles = 0;
  logic [31:0] exp_ret = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit (got no finish, expected finish)");
    $fatal(1);
  end

  // Scoreboard consumer: one expected control word per driven cycle.
  always @(negedge clk) begin
    if (mem_req) req_cycles++;
    if (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      mon_got.st = state;      mon_got.req = mem_req;   mon_got.we = mem_we;
      mon_got.as = addr_src;   mon_got.ifw = instr_flop_wen;
      mon_got.pcw = pc_wen;    mon_got.rw = reg_write;
      mon_got.a = alu_a_src;   mon_got.b = alu_b_src;   mon_got.res = result_src;
      mon_got.imm = imm_sel;   mon_got.alu = alu_control;
      mon_got.trap = trap;     mon_got.cause = trap_cause;
      vectors++;
      if (mon_got !== mon_exp) begin
        miscompares++;
        $display("FAIL ctl t=%0t got=%h expected=%h (st %0d vs %0d)",
                 $time, mon_got, mon_exp, mon_got.st, mon_exp.st);
      end
    end
  end

  function automatic ctl_t d(input logic [3:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic ctl_t f_ack();
    ctl_t c;
    c = d(ST_FETCH);
    c.req = 1'b1; c.ifw = 1'b1; c.pcw = 1'b1; c.b = 2'b10; c.res = 2'b10;
    return c;
  endfunction

  function automatic ctl_t dec();
    ctl_t c;
    c = d(ST_DECODE);
    c.a = 2'b01; c.b = 2'b01; c.imm = 3'd2;
    return c;
  endfunction

  function automatic ctl_t trapped(input logic [1:0] cause);
    ctl_t c;
    c = d(ST_TRAP);
    c.trap = 1'b1; c.cause = cause;
    return c;
  endfunction

  // Drive one cycle's inputs and queue what the control word must be in it.
  task automatic cyc(input logic ack, input ctl_t e);
    mem_ack = ack;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b1;
    #2;
    vectors++;
    if (mem_req !== 1'b0 || state !== ST_FETCH || retired !== 32'd0 || trap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got req=%b st=%0d ret=%0d trap=%b, expected 0/0/0/0",
               mem_req, state, retired, trap);
    end
    sb.push_back(d(ST_FETCH));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_ack = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_addi();
    ctl_t e;
    opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'd0;
    cyc(1'b1, f_ack());
    cyc(1'b0, dec());
    e = d(ST_EXEC_I); e.a = 2'b10; e.b = 2'b01; cyc(1'b0, e);
    e = d(ST_ALUWB);  e.rw = 1'b1;              cyc(1'b0, e);
    exp_ret++;
    vectors++;
    if (retired !== exp_ret) begin
      miscompares++;
      $display("FAIL addi_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_load_wait();
    ctl_t e;
    opcode = 7'b0000011; funct3 = 3'b010;
    cyc(1'b1, f_ack());
    cyc(1'b0, dec());
    req_cycles = 0;
    e = d(ST_MEMADR); e.a = 2'b10; e.b = 2'b01; cyc(1'b0, e);
    e = d(ST_MEMRD);  e.req = 1'b1; e.as = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, e);
    cyc(1'b1, e);
    e = d(ST_MEMWB);  e.res = 2'b01; e.rw = 1'b1; cyc(1'b0, e);
    exp_ret++;
    vectors++;
    if (req_cycles !== 4 || retired !== exp_ret) begin
      miscompares++;
      $display("FAIL load_wait: got req_cycles=%0d retired=%0d, expected 4 and %0d",
               req_cycles, retired, exp_ret);
    end
  endtask

  task automatic test_store();
    ctl_t e;
    opcode = 7'b0100011; funct3 = 3'b010;
    cyc(1'b1, f_ack());
    cyc(1'b0, dec());
    e = d(ST_MEMADR); e.a = 2'b10; e.b = 2'b01; e.imm = 3'd1; cyc(1'b0, e);
    e = d(ST_MEMWR);  e.req = 1'b1; e.we = 1'b1; e.as = 1'b1; cyc(1'b1, e);
    exp_ret++;
    vectors++;
    if (retired !== exp_ret || state !== ST_FETCH) begin
      miscompares++;
      $display("FAIL store_retire: got ret=%0d st=%0d, expected %0d/%0d", retired, state, exp_ret, ST_FETCH);
    end
  endtask

  task automatic test_branch();
    // {funct3, alu_zero, alu op, taken}
    logic [8:0] tbl [6];
    ctl_t e;
    tbl[0] = {3'b000, 1'b1, 4'd1, 1'b1};  // BEQ equal
    tbl[1] = {3'b000, 1'b0, 4'd1, 1'b0};  // BEQ unequal
    tbl[2] = {3'b001, 1'b1, 4'd1, 1'b0};  // BNE equal
    tbl[3] = {3'b100, 1'b0, 4'd8, 1'b1};  // BLT less
    tbl[4] = {3'b101, 1'b0, 4'd8, 1'b0};  // BGE less
    tbl[5] = {3'b111, 1'b1, 4'd9, 1'b1};  // BGEU not less
    opcode = 7'b1100011;
    for (int i = 0; i < 6; i++) begin
      funct3 = tbl[i][8:6]; alu_zero = tbl[i][5];
      cyc(1'b1, f_ack());
      cyc(1'b0, dec());
      e = d(ST_BRANCH); e.a = 2'b10; e.alu = tbl[i][4:1]; e.pcw = tbl[i][0];
      cyc(1'b0, e);
      exp_ret++;
    end
    alu_zero = 1'b0;
    vectors++;
    if (retired !== exp_ret) begin
      miscompares++;
      $display("FAIL branch_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_alu_ops();
    // {opcode, funct3, funct7[5], alu op}
    logic [14:0] tbl [11];
    ctl_t e;
    tbl[0]  = {7'b0110011, 3'b000, 1'b1, 4'd1};  // SUB
    tbl[1]  = {7'b0110011, 3'b000, 1'b0, 4'd0};  // ADD
    tbl[2]  = {7'b0010011, 3'b000, 1'b1, 4'd0};  // ADDI never subtracts
    tbl[3]  = {7'b0010011, 3'b101, 1'b1, 4'd7};  // SRAI
    tbl[4]  = {7'b0110011, 3'b101, 1'b0, 4'd6};  // SRL
    tbl[5]  = {7'b0110011, 3'b011, 1'b0, 4'd9};  // SLTU
    tbl[6]  = {7'b0010011, 3'b010, 1'b0, 4'd8};  // SLTI
    tbl[7]  = {7'b0110011, 3'b111, 1'b0, 4'd2};  // AND
    tbl[8]  = {7'b0010011, 3'b110, 1'b0, 4'd3};  // ORI
    tbl[9]  = {7'b0110011, 3'b100, 1'b0, 4'd4};  // XOR
    tbl[10] = {7'b0010011, 3'b001, 1'b0, 4'd5};  // SLLI
    for (int i = 0; i < 11; i++) begin
      opcode = tbl[i][14:8]; funct3 = tbl[i][7:5]; funct7 = {1'b0, tbl[i][4], 5'd0};
      cyc(1'b1, f_ack());
      cyc(1'b0, dec());
      e = d(opcode[5] ? ST_EXEC_R : ST_EXEC_I);
      e.a = 2'b10; e.b = opcode[5] ? 2'b00 : 2'b01; e.alu = tbl[i][3:0];
      cyc(1'b0, e);
      e = d(ST_ALUWB); e.rw = 1'b1; cyc(1'b0, e);
      exp_ret++;
    end
    funct7 = 7'd0;
    opcode = 7'b0010111;
    cyc(1'b1, f_ack());
    cyc(1'b0, dec());
    e = d(ST_AUIPC); e.a = 2'b01; e.b = 2'b01; e.imm = 3'd3; cyc(1'b0, e);
    e = d(ST_ALUWB); e.rw = 1'b1; cyc(1'b0, e);
    opcode = 7'b0110111;
    cyc(1'b1, f_ack());
    cyc(1'b0, dec());
    e = d(ST_LUI); e.imm = 3'd3; e.res = 2'b11; e.rw = 1'b1; cyc(1'b0, e);
    exp_ret += 2;
    vectors++;
    if (retired !== exp_ret) begin
      miscompares++;
      $display("FAIL alu_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_jumps();
    ctl_t e, link;
    link = d(ST_LINK); link.a = 2'b01; link.b = 2'b10; link.res = 2'b10; link.rw = 1'b1;
    opcode = 7'b1101111;
    cyc(1'b1, f_ack());
    cyc(1'b0, dec());
    e = d(ST_JAL); e.a = 2'b01; e.b = 2'b01; e.imm = 3'd4; e.res = 2'b10; e.pcw = 1'b1;
    cyc(1'b0, e);
    cyc(1'b0, link);
    opcode = 7'b1100111; funct3 = 3'b000;
    cyc(1'b1, f_ack());
    cyc(1'b0, dec());
    e = d(ST_JALR);  e.a = 2'b10; e.b = 2'b01; cyc(1'b0, e);
    e = d(ST_JALR2); e.a = 2'b11; e.b = 2'b11; e.alu = 4'd2; e.res = 2'b10; e.pcw = 1'b1;
    cyc(1'b0, e);
    cyc(1'b0, link);
    exp_ret += 2;
    vectors++;
    if (retired !== exp_ret) begin
      miscompares++;
      $display("FAIL jump_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid_store();
    ctl_t e;
    opcode = 7'b0100011; funct3 = 3'b010;
    cyc(1'b1, f_ack());
    cyc(1'b0, dec());
    e = d(ST_MEMADR); e.a = 2'b10; e.b = 2'b01; e.imm = 3'd1; cyc(1'b0, e);
    e = d(ST_MEMWR);  e.req = 1'b1; e.we = 1'b1; e.as = 1'b1;
    cyc(1'b0, e);
    cyc(1'b0, e);
    #1;
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || retired === 32'd0) begin
      miscompares++;
      $display("FAIL pre_reset_write: got req=%b we=%b ret=%0d, expected 1/1/nonzero",
               mem_req, mem_we, retired);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== ST_FETCH || retired !== 32'd0 || trap !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got req=%b we=%b st=%0d ret=%0d trap=%b, expected 0/0/0/0/0",
               mem_req, mem_we, state, retired, trap);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; mem_ack = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_illegal();
    opcode = 7'h7F;
    cyc(1'b1, f_ack());
    cyc(1'b0, dec());
    req_cycles = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, trapped(2'd1));
    vectors++;
    if (req_cycles !== 0 || retired !== exp_ret) begin
      miscompares++;
      $display("FAIL illegal_trap: got req_cycles=%0d ret=%0d, expected 0 and %0d",
               req_cycles, retired, exp_ret);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; mem_ack = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_timeout();
    ctl_t e;
    opcode = 7'b0010011;
    e = d(ST_FETCH); e.req = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, e);
    for (int i = 0; i < 2; i++) cyc(1'b1, trapped(2'd2));
    vectors++;
    if (retired !== exp_ret) begin
      miscompares++;
      $display("FAIL timeout_retired: got %0d expected %0d", retired, exp_ret);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; alu_zero = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    test_reset();
    test_addi();
    test_load_wait();
    test_store();
    test_branch();
    test_alu_ops();
    test_jumps();
    test_reset_mid_store();
    test_illegal();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
